// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Loadable down-counter with IDLE/RUN/HOLD control, pause and
//                a single-cycle done pulse; decrement built from a ripple
//                chain of full-adder cells.
//  Revision    : 1.0  initial release
// ============================================================================
module countdown_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    localparam logic [1:0]       c_IDLE = 2'd0;
    localparam logic [1:0]       c_RUN  = 2'd1;
    localparam logic [1:0]       c_HOLD = 2'd2;
    localparam logic [WIDTH-1:0] c_ONES = '1;
    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_done;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_done_nxt;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_carry;
    logic             w_zero;
    logic             w_is_one;

    // count + all-ones with carry-in 0; the carry out of the top cell is dropped
    assign w_carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign w_dec[gi] = r_count[gi] ^ c_ONES[gi] ^ w_carry[gi];
            if (gi < WIDTH - 1) begin : g_carry
                assign w_carry[gi+1] = (r_count[gi] & c_ONES[gi])
                                     | (r_count[gi] & w_carry[gi])
                                     | (c_ONES[gi]  & w_carry[gi]);
            end
        end
    endgenerate

    assign w_zero   = (r_count == '0);
    assign w_is_one = (r_count == c_ONE);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (load) begin
                    w_count_nxt = load_val;
                end else if (start) begin
                    if (w_zero) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = c_RUN;
                    end
                end
            end
            c_RUN: begin
                if (load) begin
                    w_count_nxt = load_val;
                    w_state_nxt = c_IDLE;
                end else if (pause) begin
                    w_state_nxt = c_HOLD;
                end else if (w_zero) begin
                    // Unreachable in normal operation; guards against wrapping 0 -> all-ones
                    w_state_nxt = c_IDLE;
                end else begin
                    w_count_nxt = w_dec;
                    if (w_is_one) begin
                        w_state_nxt = c_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            c_HOLD: begin
                if (load) begin
                    w_count_nxt = load_val;
                    w_state_nxt = c_IDLE;
                end else if (!pause) begin
                    w_state_nxt = c_RUN;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign count = r_count;
    assign done  = r_done;
    assign busy  = (r_state == c_RUN) || (r_state == c_HOLD);
    assign zero  = w_zero;

endmodule
`default_nettype wire
